// File: rtl/alu_core.sv
// RV32I execute-stage integer ALU: combinational operation select feeding a
// single output register stage that carries result, zero flag and valid.
module alu_core #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [3:0]      i_alu_ctrl,
    output logic [XLEN-1:0] o_result,
    output logic            o_valid,
    output logic            o_zero
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_BUF  = 4'b1000,
        ALU_SLT  = 4'b1001,
        ALU_SLTU = 4'b1010,
        ALU_EQ   = 4'b1011,
        ALU_GE   = 4'b1100,
        ALU_GEU  = 4'b1101
    } alu_op_e;

    logic [SHW-1:0]  shamt;
    logic            lt_signed;
    logic            lt_unsigned;
    logic            eq;
    logic [XLEN-1:0] alu_d;

    // Only the low shift-amount bits of op2 matter; upper bits are ignored.
    assign shamt       = i_op2[SHW-1:0];
    assign lt_signed   = $signed(i_op1) < $signed(i_op2);
    assign lt_unsigned = i_op1 < i_op2;
    assign eq          = i_op1 == i_op2;

    always_comb begin
        alu_d = '0;
        case (i_alu_ctrl)
            ALU_ADD:  alu_d = i_op1 + i_op2;
            ALU_SUB:  alu_d = i_op1 - i_op2;
            ALU_AND:  alu_d = i_op1 & i_op2;
            ALU_OR:   alu_d = i_op1 | i_op2;
            ALU_XOR:  alu_d = i_op1 ^ i_op2;
            ALU_SRL:  alu_d = i_op1 >> shamt;
            ALU_SLL:  alu_d = i_op1 << shamt;
            ALU_SRA:  alu_d = $unsigned($signed(i_op1) >>> shamt);
            ALU_BUF:  alu_d = i_op2;
            ALU_SLT:  alu_d = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: alu_d = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_EQ:   alu_d = {{(XLEN-1){1'b0}}, eq};
            ALU_GE:   alu_d = {{(XLEN-1){1'b0}}, ~lt_signed};
            ALU_GEU:  alu_d = {{(XLEN-1){1'b0}}, ~lt_unsigned};
            default:  alu_d = '0;
        endcase
    end

    // Valid semantics: o_valid follows i_valid one edge later with no stall;
    // o_result/o_zero load only on valid input and otherwise hold, so a
    // consumer must qualify them with o_valid. Reset wins over i_valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_result <= '0;
            o_valid  <= 1'b0;
            o_zero   <= 1'b1;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_result <= alu_d;
                o_zero   <= (alu_d == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: table of hand-computed results applied
// back-to-back, plus hand-written hold and reset sequences.
module tb_alu_core;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic [3:0]  i_alu_ctrl;
    logic [31:0] o_result;
    logic        o_valid;
    logic        o_zero;

    int n_applied = 0;
    int n_miss    = 0;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] exp_result;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    alu_core #(.XLEN(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_op1      (i_op1),
        .i_op2      (i_op2),
        .i_alu_ctrl (i_alu_ctrl),
        .o_result   (o_result),
        .o_valid    (o_valid),
        .o_zero     (o_zero)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] ctrl, input logic [31:0] op1,
                           input logic [31:0] op2, input logic [31:0] exp_result);
        vec_t v;
        v.name       = name;
        v.ctrl       = ctrl;
        v.op1        = op1;
        v.op2        = op2;
        v.exp_result = exp_result;
        v.exp_zero   = (exp_result == 32'h0);
        vecs.push_back(v);
    endtask

    // drive inputs on the falling edge, then step past the next rising edge
    task automatic drive(input logic rst, input logic valid, input logic [3:0] ctrl,
                         input logic [31:0] op1, input logic [31:0] op2);
        @(negedge i_clk);
        i_rst      = rst;
        i_valid    = valid;
        i_alu_ctrl = ctrl;
        i_op1      = op1;
        i_op2      = op2;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_outputs(input string name, input logic [31:0] exp_result,
                                 input logic exp_valid, input logic exp_zero);
        check({name, ".result"}, o_result, exp_result);
        check({name, ".valid"}, {31'b0, o_valid}, {31'b0, exp_valid});
        check({name, ".zero"}, {31'b0, o_zero}, {31'b0, exp_zero});
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_alu_ctrl = 4'h0; i_op1 = '0; i_op2 = '0;

        add_vec("add",       4'b0000, 32'd10,        32'd20,        32'd30);
        add_vec("sub",       4'b0001, 32'd50,        32'd25,        32'd25);
        add_vec("and",       4'b0010, 32'd15,        32'd3,         32'd3);
        add_vec("or",        4'b0011, 32'd7,         32'd12,        32'd15);
        add_vec("xor",       4'b0100, 32'd11,        32'd5,         32'd14);
        add_vec("add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'd1,         32'h0);
        add_vec("sub_wrap",  4'b0001, 32'd0,         32'd1,         32'hFFFF_FFFF);
        add_vec("srl",       4'b0101, 32'd80,        32'd3,         32'd10);
        add_vec("sll",       4'b0110, 32'd3,         32'd4,         32'd48);
        add_vec("sra_neg",   4'b0111, 32'hFFFF_FFD0, 32'd2,         32'hFFFF_FFF4);
        add_vec("sll_hi",    4'b0110, 32'd1,         32'h21,        32'd2);
        add_vec("sll_0",     4'b0110, 32'hA5A5_0F0F, 32'h20,        32'hA5A5_0F0F);
        add_vec("srl_31",    4'b0101, 32'h8000_0000, 32'd31,        32'd1);
        add_vec("sra_31",    4'b0111, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF);
        add_vec("sra_pos",   4'b0111, 32'h4000_0000, 32'd4,         32'h0400_0000);
        add_vec("buf",       4'b1000, 32'd10,        32'd20,        32'd20);
        add_vec("slt_f",     4'b1001, 32'hFFFF_FFF6, 32'hFFFF_FFEC, 32'd0);
        add_vec("slt_t",     4'b1001, 32'hFFFF_FFEC, 32'hFFFF_FFF6, 32'd1);
        add_vec("slt_min",   4'b1001, 32'h8000_0000, 32'd1,         32'd1);
        add_vec("ge_30_20",  4'b1100, 32'd30,        32'd20,        32'd1);
        add_vec("ge_50_20",  4'b1100, 32'd50,        32'd20,        32'd1);
        add_vec("ge_m1_0",   4'b1100, 32'hFFFF_FFFF, 32'd0,         32'd0);
        add_vec("ge_eq",     4'b1100, 32'd7,         32'd7,         32'd1);
        add_vec("sltu",      4'b1010, 32'hFFFF_FFEC, 32'd10,        32'd0);
        add_vec("sltu_t",    4'b1010, 32'd10,        32'hFFFF_FFEC, 32'd1);
        add_vec("geu_f",     4'b1101, 32'd20,        32'd30,        32'd0);
        add_vec("geu_t",     4'b1101, 32'hFFFF_FF9C, 32'd30,        32'd1);
        add_vec("eq_t",      4'b1011, 32'd10,        32'd10,        32'd1);
        add_vec("eq_f",      4'b1011, 32'd10,        32'd20,        32'd0);
        add_vec("rsv_1110",  4'b1110, 32'd5,         32'd6,         32'd0);
        add_vec("rsv_1111",  4'b1111, 32'd5,         32'd6,         32'd0);

        // reset state
        drive(1'b1, 1'b0, 4'h0, '0, '0);
        drive(1'b1, 1'b1, 4'b1000, 32'd0, 32'd99);
        check_outputs("reset", 32'h0, 1'b0, 1'b1);

        // first valid after reset shows up one edge later
        drive(1'b0, 1'b0, 4'h0, '0, '0);
        check_outputs("post_reset_idle", 32'h0, 1'b0, 1'b1);

        // back-to-back table vectors, one valid op per cycle
        foreach (vecs[i]) begin
            drive(1'b0, 1'b1, vecs[i].ctrl, vecs[i].op1, vecs[i].op2);
            check_outputs(vecs[i].name, vecs[i].exp_result, 1'b1, vecs[i].exp_zero);
        end

        // hold: i_valid low with changing operands keeps result/zero
        drive(1'b0, 1'b1, 4'b0000, 32'd1, 32'd2);
        check_outputs("hold_load", 32'd3, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
            check_outputs("hold", 32'd3, 1'b0, 1'b0);
        end

        // hold after a zero result keeps o_zero high
        drive(1'b0, 1'b1, 4'b0001, 32'd9, 32'd9);
        check_outputs("zero_load", 32'd0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 4'b0000, 32'd4, 32'd4);
        check_outputs("zero_hold", 32'd0, 1'b0, 1'b1);

        // reset mid-stream with i_valid high discards the operation
        drive(1'b0, 1'b1, 4'b0011, 32'hF0, 32'h0F);
        check_outputs("pre_rst", 32'hFF, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 4'b0000, 32'd100, 32'd200);
        check_outputs("mid_rst", 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'b0000, 32'd100, 32'd200);
        check_outputs("after_rst", 32'd300, 1'b1, 1'b0);

        @(negedge i_clk);
        i_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
